systolic_ctrl: RTL

Job sequencer for the matrix-multiply datapath: memA (A operand rows), memB (B skew buffer) and the DIM×DIM systolic_array. One `start` pulse runs a full job: it loads DIM A rows, streams DIM B rows, drains the pipeline, reads out DIM C rows, and optionally clears the accumulators. The host sits on one side through valid/ready handshakes; the datapath control pins sit on the other.

---
 rtl/sysctrl_pkg.sv | 18 +
 rtl/systolic_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sysctrl_pkg.sv
// sysctrl_pkg: state encoding and timing constants shared by the systolic_ctrl job sequencer.
package sysctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        STREAM,
        DRAIN,
        READ_C,
        CLEAR_C,
        DONE
    } sysctrl_state_t;

    localparam int DIM_DEFAULT  = 8;
    localparam int DRAIN_CYCLES = 2 * DIM_DEFAULT;
    localparam int READ_SETTLE  = 1;

endpackage

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for memA/memB/systolic_array (load A, stream B, drain, read C, clear C).
// Define SYSCTRL_CLEAR_EN to compile in the CLEAR_C phase; otherwise accumulators persist across jobs.
module systolic_ctrl
    import sysctrl_pkg::*;
#(
    parameter int DIM     = DIM_DEFAULT,
    parameter int BITS_AB = 8,
    parameter int ROWBITS = $clog2(DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIM*BITS_AB-1:0]   in_data,
    output logic [DIM*BITS_AB-1:0]   ab_data,
    output logic                     mem_a_wren,
    output logic [ROWBITS-1:0]       mem_a_row,
    output logic                     mem_en,
    output logic                     sa_wren,
    output logic [ROWBITS-1:0]       sa_crow,
    output logic                     c_valid,
    input  logic                     c_ready
);

    // drain length scales with DIM at the package's cycles-per-row ratio
    localparam int DRAIN_N = DRAIN_CYCLES / DIM_DEFAULT * DIM;
    localparam int DW      = $clog2(DRAIN_N);

    sysctrl_state_t state_q, state_d;
    logic [ROWBITS:0] cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0]    drn_q, drn_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drn_d      = drn_q;
        cnt_inc    = cnt_q + 1'b1;
        busy       = state_q != IDLE;
        done       = state_q == DONE;
        in_ready   = 1'b0;
        ab_data    = '0;
        mem_a_wren = 1'b0;
        mem_a_row  = '0;
        mem_en     = 1'b0;
        sa_wren    = 1'b0;
        sa_crow    = '0;
        c_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = start ? LOAD_A : IDLE;
                cnt_d   = '0;
            end
            LOAD_A: begin
                in_ready   = 1'b1;
                ab_data    = in_data;
                mem_a_wren = in_valid;
                mem_a_row  = cnt_q[ROWBITS-1:0];
                if (in_valid) begin
                    cnt_d   = cnt_inc[ROWBITS] ? '0 : cnt_inc;
                    state_d = cnt_inc[ROWBITS] ? STREAM : LOAD_A;
                end
            end
            STREAM: begin
                in_ready = 1'b1;
                ab_data  = in_data;
                mem_en   = in_valid;
                if (in_valid) begin
                    cnt_d   = cnt_inc[ROWBITS] ? '0 : cnt_inc;
                    state_d = cnt_inc[ROWBITS] ? DRAIN : STREAM;
                    drn_d   = '0;
                end
            end
            DRAIN: begin
                mem_en = 1'b1;
                drn_d  = drn_q + 1'b1;
                if (drn_q == DW'(DRAIN_N - 1)) begin
                    state_d = READ_C;
                    cnt_d   = '0;
                    drn_d   = '0;
                end
            end
            READ_C: begin
                // drn_q doubles as the settle counter; Cout is valid once it reaches READ_SETTLE
                sa_crow = cnt_q[ROWBITS-1:0];
                c_valid = drn_q == DW'(READ_SETTLE);
                if (!c_valid) begin
                    drn_d = drn_q + 1'b1;
                end else if (c_ready) begin
                    drn_d = '0;
                    cnt_d = cnt_inc[ROWBITS] ? '0 : cnt_inc;
`ifdef SYSCTRL_CLEAR_EN
                    state_d = cnt_inc[ROWBITS] ? CLEAR_C : READ_C;
`else
                    state_d = cnt_inc[ROWBITS] ? DONE : READ_C;
`endif
                end
            end
`ifdef SYSCTRL_CLEAR_EN
            CLEAR_C: begin
                sa_wren = 1'b1;
                sa_crow = cnt_q[ROWBITS-1:0];
                cnt_d   = cnt_inc[ROWBITS] ? '0 : cnt_inc;
                state_d = cnt_inc[ROWBITS] ? DONE : CLEAR_C;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
